// File: rtl/fixed_point_onehot_arbiter_pkg.sv
// Shared definitions for the fixed-point one-hot arbiter: default sizes,
// the fixed-point word type and a small index-width helper.
package fixed_point_onehot_arbiter_pkg;

  // Default number of requesters.
  localparam int DEF_N    = 4;
  // Default word width; words are signed two's complement.
  localparam int DEF_W    = 16;
  // Default count of fractional bits (binary point position only).
  localparam int DEF_FRAC = 8;

  // Fixed-point word at the default width (Q7.8 with the defaults).
  typedef logic signed [DEF_W-1:0] fxp_word_t;

  // Bits needed to hold an index in 0..n-1, never less than one.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fixed_point_onehot_arbiter_picker.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// set request found searching upward from (last+1) mod N, wrapping.
module rr_onehot_picker
  import fixed_point_onehot_arbiter_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int LW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant
);

  logic found;

  // Index reached k steps above the last winner, wrapped into 0..N-1.
  function automatic logic [LW-1:0] wrap_idx(input logic [LW-1:0] base, input int k);
    return LW'((int'(base) + k) % N);
  endfunction

  // Walk the N candidates in priority order; the first set request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[wrap_idx(last, k)]) begin
        grant[wrap_idx(last, k)] = 1'b1;
        found                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fixed_point_onehot_arbiter.sv
// Round-robin arbiter over N fixed-point requesters. The winning word is
// moved bit-exact into a single output register together with its one-hot
// grant. FRAC only documents where the binary point sits.
//
// Handshake: a word moves on any port when valid and ready are both high
// on a rising clock edge. An input i is ready only when the output register
// can load (empty, or draining this cycle) and i is the round-robin winner;
// in_ready never looks at in_data. Valid must not depend on ready.
module fixed_point_onehot_arbiter
  import fixed_point_onehot_arbiter_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int W    = DEF_W,
  parameter int FRAC = DEF_FRAC
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic [N*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic [N-1:0]   out_grant
);

  localparam int LW = idx_width(N);

  // Reject parameter sets the arbiter cannot represent.
  if (N < 2) begin : g_bad_n
    $error("fixed_point_onehot_arbiter: N must be at least 2");
  end
  if (FRAC >= W) begin : g_bad_frac
    $error("fixed_point_onehot_arbiter: FRAC must be below W");
  end

  logic [LW-1:0] last;
  logic [N-1:0]  grant;
  logic [LW-1:0] grant_idx;
  logic [W-1:0]  sel_word;
  logic          load;
  logic          any_valid;

  // Output register can take a word when empty or when its word leaves now.
  assign load      = !out_valid || out_ready;
  assign any_valid = |in_valid;

  rr_onehot_picker #(
    .N  (N),
    .LW (LW)
  ) u_picker (
    .req   (in_valid),
    .last  (last),
    .grant (grant)
  );

  // Ready is the grant itself, gated by load and held low during reset.
  always_comb begin
    in_ready = '0;
    if (reset && load) begin
      in_ready = grant;
    end
  end

  // One-hot data mux: OR of the words whose grant bit is set.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_word = sel_word | in_data[i*W +: W];
      end
    end
  end

  // Encode the one-hot grant into the index remembered for fairness.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        grant_idx = LW'(i);
      end
    end
  end

  // Output register and round-robin pointer; both only move when loading.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_grant <= '0;
      last      <= LW'(N - 1);
    end else if (load) begin
      if (any_valid) begin
        out_valid <= 1'b1;
        out_data  <= sel_word;
        out_grant <= grant;
        last      <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_onehot_arbiter.sv
// Bench for fixed_point_onehot_arbiter: vector table, directed corner
// sequences and a randomized run against a reference model.
module tb_fixed_point_onehot_arbiter;
  import fixed_point_onehot_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int FRAC = 8;

  // ---------------- clock / reset ----------------
  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N-1:0]   in_ready;
  logic [N*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [N-1:0]   out_grant;
  fxp_word_t      words[N];

  always #5 clock = ~clock;

  always_comb begin
    in_data = '0;
    for (int i = 0; i < N; i++) in_data[i*W +: W] = words[i];
  end

  fixed_point_onehot_arbiter #(.N(N), .W(W), .FRAC(FRAC)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_grant (out_grant)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at edge+1: drive inputs, sample pre-edge values, return at edge+1.
  task automatic apply(input logic [N-1:0] v, input logic r,
                       output logic [N-1:0] ir, output logic pv, output logic [W-1:0] pd);
    in_valid  = v;
    out_ready = r;
    #2;
    ir = in_ready;
    pv = out_valid;
    pd = out_data;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #3;
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic default_words();
    for (int i = 0; i < N; i++) words[i] = fxp_word_t'(16'h0100 * (i + 1));
  endtask

  // ---------------- reference model ----------------
  // Winner is the valid requester at the smallest cyclic distance past last.
  function automatic int pick(input logic [N-1:0] v, input int last);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        d = (i - last - 1 + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] v;
    logic         r;
    logic [N-1:0] exp_ir;
    logic         exp_ov;
    logic [N-1:0] exp_g;
    logic [W-1:0] exp_d;
  } vec_t;

  vec_t tbl[16];
  int   n_vec = 0;

  task automatic add(input logic [N-1:0] v, input logic r, input logic [N-1:0] ir,
                     input logic ov, input logic [N-1:0] g, input logic [W-1:0] d);
    tbl[n_vec].v      = v;
    tbl[n_vec].r      = r;
    tbl[n_vec].exp_ir = ir;
    tbl[n_vec].exp_ov = ov;
    tbl[n_vec].exp_g  = g;
    tbl[n_vec].exp_d  = d;
    n_vec++;
  endtask

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  // ---------------- main ----------------
  initial begin
    logic [N-1:0] ir;
    logic         pv;
    logic [W-1:0] pd;
    logic [N-1:0] pend;
    int           wait_cnt[N];
    logic         m_valid;
    logic [W-1:0] m_data;
    logic [N-1:0] m_grant;
    int           m_last;
    logic         r;
    logic         mload;
    int           p;
    logic [N-1:0] e_ir;
    logic [W-1:0] e_d;

    // Rows start from reset (last = N-1), words 0x0100,0x0200,0x0300,0x0400.
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 16'h0100);
    add(4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 16'h0200);
    add(4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100, 16'h0300);
    add(4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h0400);
    add(4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001, 16'h0100);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 16'h0100);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 16'h0100);
    add(4'b1111, 1'b0, 4'b0000, 1'b1, 4'b0001, 16'h0100);
    add(4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010, 16'h0200);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0010, 16'h0200);
    add(4'b1000, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h0400);
    add(4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001, 16'h0100);
    add(4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000, 16'h0400);
    add(4'b0000, 1'b0, 4'b0000, 1'b1, 4'b1000, 16'h0400);
    add(4'b0000, 1'b1, 4'b0000, 1'b0, 4'b1000, 16'h0400);
    add(4'b0100, 1'b0, 4'b0100, 1'b1, 4'b0100, 16'h0300);

    // Reset state.
    default_words();
    do_reset();
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_grant", 64'(out_grant), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);

    // Table-driven vectors.
    for (int k = 0; k < n_vec; k++) begin
      apply(tbl[k].v, tbl[k].r, ir, pv, pd);
      check($sformatf("vec%0d_in_ready", k),  64'(ir),        64'(tbl[k].exp_ir));
      check($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].exp_ov));
      check($sformatf("vec%0d_out_grant", k), 64'(out_grant), 64'(tbl[k].exp_g));
      check($sformatf("vec%0d_out_data", k),  64'(out_data),  64'(tbl[k].exp_d));
    end

    // Negative fixed-point word passes bit-exact from requester 2.
    do_reset();
    default_words();
    words[2] = fxp_word_t'(16'hFF80);
    apply(4'b0100, 1'b1, ir, pv, pd);
    check("neg_in_ready",  64'(ir),        64'(4'b0100));
    check("neg_out_valid", 64'(out_valid), 64'd1);
    check("neg_out_data",  64'(out_data),  64'(16'hFF80));
    check("neg_out_grant", 64'(out_grant), 64'(4'b0100));

    // Asynchronous reset mid-stream, then restart from index 0.
    do_reset();
    default_words();
    for (int k = 0; k < 3; k++) apply(4'b1111, 1'b1, ir, pv, pd);
    check("pre_arst_grant", 64'(out_grant), 64'(4'b0100));
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_grant", 64'(out_grant), 64'd0);
    check("arst_out_data",  64'(out_data),  64'd0);
    check("arst_in_ready",  64'(in_ready),  64'd0);
    @(posedge clock);
    #1;
    check("arst_hold_valid", 64'(out_valid), 64'd0);
    #2;
    reset = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'(4'b0001));
    @(posedge clock);
    #1;
    check("rel_out_grant", 64'(out_grant), 64'(4'b0001));
    check("rel_out_valid", 64'(out_valid), 64'd1);
    check("rel_out_data",  64'(out_data),  64'(16'h0100));

    // Randomized run against the model, requesters hold valid until accepted.
    do_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_grant = '0;
    m_last  = N - 1;
    pend    = '0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
          pend[i]     = 1'b1;
          words[i]    = fxp_word_t'($urandom_range(0, 65535));
          wait_cnt[i] = 0;
        end
      end
      r     = ($urandom_range(0, 3) != 0);
      mload = !m_valid || r;
      p     = pick(pend, m_last);
      e_ir  = (mload && p >= 0) ? N'(1 << p) : '0;
      apply(pend, r, ir, pv, pd);
      check("rnd_in_ready", 64'(ir), 64'(e_ir));
      if (m_valid && r) begin
        if (exp_q.size() == 0) begin
          check("rnd_sb_underflow", 64'd1, 64'd0);
        end else begin
          e_d = exp_q.pop_front();
          check("rnd_sb_data", 64'(pd), 64'(e_d));
        end
      end
      if (mload) begin
        if (p >= 0) begin
          check("rnd_fair_wait", 64'(wait_cnt[p] <= N - 1), 64'd1);
          for (int j = 0; j < N; j++) if (j != p && pend[j]) wait_cnt[j]++;
          m_valid = 1'b1;
          m_data  = words[p];
          m_grant = N'(1 << p);
          m_last  = p;
          pend[p] = 1'b0;
          exp_q.push_back(words[p]);
        end else begin
          m_valid = 1'b0;
        end
      end
      check("rnd_out_valid", 64'(out_valid), 64'(m_valid));
      check("rnd_out_grant", 64'(out_grant), 64'(m_grant));
      check("rnd_out_data",  64'(out_data),  64'(m_data));
      if (out_valid) check("rnd_onehot", 64'($countones(out_grant)), 64'd1);
    end

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
